// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared fixed-point helpers for the MAC datapath
//
// Purpose: default widths and the rounding/saturation helpers used by the
// multiply-accumulate lanes and other fixed-point units.
// Ports: none (package).
//
// Helpers work on a 64-bit signed intermediate, so any width up to 63 bits
// can be rounded or clamped. Callers truncate the result to their own width.
package mac_pkg;

  localparam int MAC_DWIDTH = 16;
  localparam int MAC_FRAC   = 8;
  localparam int MAC_LANES  = 4;
  localparam int MAC_AWIDTH = 2 * MAC_DWIDTH;
  localparam int MAC_CWIDTH = 10;
  localparam int WIDE       = 64;

  typedef struct packed {
    logic            hit;
    logic [WIDE-1:0] val;
  } sat_t;

  // Round to nearest with ties away from zero, then drop frac bits.
  function automatic logic signed [WIDE-1:0] round_prod(input logic signed [WIDE-1:0] p,
                                                        input int frac);
    logic signed [WIDE-1:0] half;
    logic signed [WIDE-1:0] neg;
    half = 64'sd1 <<< (frac - 1);
    neg  = p[WIDE-1] ? 64'sd1 : 64'sd0;
    return (p + half - neg) >>> frac;
  endfunction

  // Clamp v to the signed range of 'width' bits; hit flags a clamp.
  function automatic sat_t sat(input logic signed [WIDE-1:0] v, input int width);
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    sat_t s;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) begin
      s.hit = 1'b1;
      s.val = hi;
    end else if (v < lo) begin
      s.hit = 1'b1;
      s.val = lo;
    end else begin
      s.hit = 1'b0;
      s.val = v;
    end
    return s;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one lane of the multiply-accumulate datapath
//
// Purpose: S1 operand regs, S2 full product, S3 rounded product, S4
// accumulator with guard bits, output clamp and sticky saturation flag.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   en_i         global advance; every register holds when low
//   valid_i      S3 stage holds a valid beat
//   last_i       S3 beat is the final beat of its vector
//   first_i      S3 beat is the first beat of its vector (acc restarts)
//   x_i, w_i     lane operands entering S1
//   y_o          clamped dot-product of the last finished vector
//   sat_o        that result was clamped (acc or output)
module mac_lane
  import mac_pkg::*;
#(
  parameter int DWIDTH = MAC_DWIDTH,
  parameter int FRAC   = MAC_FRAC,
  parameter int AWIDTH = MAC_AWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic              first_i,
  input  logic [DWIDTH-1:0] x_i,
  input  logic [DWIDTH-1:0] w_i,
  output logic [DWIDTH-1:0] y_o,
  output logic              sat_o
);

  localparam int PWIDTH = 2 * DWIDTH;
  localparam int RWIDTH = 2 * DWIDTH - FRAC;

  logic signed [DWIDTH-1:0] x_q, w_q;
  logic signed [PWIDTH-1:0] p_q, p_d;
  logic signed [RWIDTH-1:0] r_q, r_d;
  logic signed [AWIDTH-1:0] acc_q, acc_d;
  logic                     sticky_q, sticky_d;
  logic        [DWIDTH-1:0] y_q, y_d;
  logic                     sat_q, sat_d;

  logic signed [PWIDTH-1:0] x_ext, w_ext;
  logic signed [WIDE-1:0]   r_wide, base, sum;
  sat_t                     acc_s, out_s;
  logic                     lane_unused;

  always_comb begin
    x_ext    = PWIDTH'(x_q);
    w_ext    = PWIDTH'(w_q);
    p_d      = x_ext * w_ext;
    r_wide   = round_prod(WIDE'(p_q), FRAC);
    r_d      = r_wide[RWIDTH-1:0];
    // First beat of a vector ignores whatever the previous vector left in acc.
    base     = first_i ? '0 : WIDE'(acc_q);
    sum      = base + WIDE'(r_q);
    acc_s    = sat(sum, AWIDTH);
    acc_d    = acc_s.val[AWIDTH-1:0];
    out_s    = sat($signed(acc_s.val), DWIDTH);
    y_d      = out_s.val[DWIDTH-1:0];
    sticky_d = last_i ? 1'b0 : (sticky_q | acc_s.hit);
    sat_d    = sticky_q | acc_s.hit | out_s.hit;
  end

  assign lane_unused = ^{r_wide[WIDE-1:RWIDTH], out_s.val[WIDE-1:DWIDTH]};

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      w_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      y_q      <= '0;
      sat_q    <= 1'b0;
    end else if (en_i) begin
      x_q <= x_i;
      w_q <= w_i;
      p_q <= p_d;
      r_q <= r_d;
      if (valid_i) begin
        acc_q    <= acc_d;
        sticky_q <= sticky_d;
        if (last_i) begin
          y_q   <= y_d;
          sat_q <= sat_d;
        end
      end
    end
  end

  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/mac_vec.sv
// rtl/mac_vec.sv - multi-lane fixed-point dot-product engine
//
// Purpose: LANES independent MAC lanes sharing one control path: handshake,
// valid/last shift chain, first-beat flag, beat counter, result register.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   in_valid_i    beat present on x_i/w_i/in_last_i
//   in_ready_o    beat accepted this cycle when in_valid_i is high
//   in_last_i     beat is the final element of its vector
//   x_i, w_i      lane i operand/weight at [i*DWIDTH +: DWIDTH]
//   out_valid_o   y_o/out_sat_o/out_len_o hold a finished result
//   out_ready_i   consumer takes the result this cycle
//   y_o           per-lane clamped dot-product, same packing as x_i
//   out_sat_o     per-lane clamp flag
//   out_len_o     beats in the finished vector, saturating
module mac_vec
  import mac_pkg::*;
#(
  parameter int DWIDTH = MAC_DWIDTH,
  parameter int FRAC   = MAC_FRAC,
  parameter int LANES  = MAC_LANES,
  parameter int AWIDTH = 2 * DWIDTH,
  parameter int CWIDTH = MAC_CWIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    in_last_i,
  input  logic [LANES*DWIDTH-1:0] x_i,
  input  logic [LANES*DWIDTH-1:0] w_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*DWIDTH-1:0] y_o,
  output logic [LANES-1:0]        out_sat_o,
  output logic [CWIDTH-1:0]       out_len_o
);

  logic              en, accept;
  logic              v1_q, v2_q, v3_q;
  logic              l1_q, l2_q, l3_q;
  logic              first_q;
  logic [CWIDTH-1:0] cnt_q, cnt_inc;
  logic [CWIDTH-1:0] out_len_q;
  logic              out_valid_q;

  // Whole pipeline stalls only when a finished result is waiting unread.
  assign en         = !out_valid_q || out_ready_i;
  assign in_ready_o = en;
  assign accept     = in_valid_i && en;
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CWIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      l1_q        <= 1'b0;
      l2_q        <= 1'b0;
      l3_q        <= 1'b0;
      first_q     <= 1'b1;
      cnt_q       <= '0;
      out_len_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (en) begin
        v1_q <= accept;
        l1_q <= accept && in_last_i;
        v2_q <= v1_q;
        l2_q <= l1_q;
        v3_q <= v2_q;
        l3_q <= l2_q;
        if (v3_q) begin
          first_q <= l3_q;
          if (l3_q) begin
            cnt_q     <= '0;
            out_len_q <= cnt_inc;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
      end
      // A completing vector on the same edge as the read keeps out_valid high.
      if (en && v3_q && l3_q) begin
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(
      .DWIDTH(DWIDTH),
      .FRAC  (FRAC),
      .AWIDTH(AWIDTH)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .en_i   (en),
      .valid_i(v3_q),
      .last_i (l3_q),
      .first_i(first_q),
      .x_i    (x_i[g*DWIDTH +: DWIDTH]),
      .w_i    (w_i[g*DWIDTH +: DWIDTH]),
      .y_o    (y_o[g*DWIDTH +: DWIDTH]),
      .sat_o  (out_sat_o[g])
    );
  end

  assign out_valid_o = out_valid_q;
  assign out_len_o   = out_len_q;

endmodule

// File: tb/tb_mac_vec.sv
// tb/tb_mac_vec.sv - directed self-checking bench for mac_vec
module tb_mac_vec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [63:0] x;
  logic [63:0] w;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] y;
  logic [3:0]  out_sat;
  logic [9:0]  out_len;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_vec #(
    .DWIDTH(16),
    .FRAC  (8),
    .LANES (4),
    .AWIDTH(32),
    .CWIDTH(10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_last_i  (in_last),
    .x_i        (x),
    .w_i        (w),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .y_o        (y),
    .out_sat_o  (out_sat),
    .out_len_o  (out_len)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] xv, input logic [63:0] wv, input logic last);
    in_valid = 1'b1;
    x        = xv;
    w        = wv;
    in_last  = last;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_result(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (out_valid) break;
      tick();
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    x = '0; w = '0;
    repeat (3) tick();
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    tests++; if (y !== 64'h0) begin fails++; $display("FAIL reset_y: got %h, expected 0", y); end
    tests++; if (out_sat !== 4'h0) begin fails++; $display("FAIL reset_sat: got %h, expected 0", out_sat); end
    tests++; if (out_len !== 10'd0) begin fails++; $display("FAIL reset_len: got %0d, expected 0", out_len); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(64'h0180, 64'h0200, 1'b0); tick();
    drive(64'h0180, 64'h0200, 1'b1); tick();
    in_valid = 1'b0; in_last = 1'b0;
    for (int e = 0; e <= 3; e++) begin
      if (e > 0) tick();
      tests++;
      if (out_valid !== (e == 3)) begin
        fails++; $display("FAIL basic_latency edge+%0d: got %b, expected %b", e, out_valid, (e == 3));
      end
    end
    tests++; if (y !== 64'h0000_0000_0000_0600) begin fails++; $display("FAIL basic_y: got %h, expected 0000000000000600", y); end
    tests++; if (out_len !== 10'd2) begin fails++; $display("FAIL basic_len: got %0d, expected 2", out_len); end
    tests++; if (out_sat !== 4'h0) begin fails++; $display("FAIL basic_sat: got %h, expected 0", out_sat); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drop: got %b, expected 0", out_valid); end
    idle(2);
  endtask

  task automatic test_rounding();
    bit ok;
    // lanes: 1*0.5 -> 1 ; -1*0.5 -> -1 ; 3*0.5=1.5 -> 2 ; -3*0.5=-1.5 -> -2 (in LSBs)
    drive(64'hFFFD_0003_FFFF_0001, 64'h0080_0080_0080_0080, 1'b1); tick();
    in_valid = 1'b0;
    wait_result(8, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL round_timeout: got %b, expected 1", ok); end
    tests++; if (y !== 64'hFFFE_0002_FFFF_0001) begin fails++; $display("FAIL round_y: got %h, expected FFFE0002FFFF0001", y); end
    tests++; if (out_sat !== 4'h0) begin fails++; $display("FAIL round_sat: got %h, expected 0", out_sat); end
    tests++; if (out_len !== 10'd1) begin fails++; $display("FAIL round_len: got %0d, expected 1", out_len); end
    idle(3);
  endtask

  task automatic test_saturation();
    bit ok;
    for (int b = 0; b < 4; b++) begin
      drive(64'h8000_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, (b == 3)); tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_result(8, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL sat_timeout: got %b, expected 1", ok); end
    tests++; if (y !== 64'h8000_7FFF_7FFF_7FFF) begin fails++; $display("FAIL sat_y: got %h, expected 80007FFF7FFF7FFF", y); end
    tests++; if (out_sat !== 4'hF) begin fails++; $display("FAIL sat_flags: got %h, expected F", out_sat); end
    tests++; if (out_len !== 10'd4) begin fails++; $display("FAIL sat_len: got %0d, expected 4", out_len); end
    idle(3);
    drive(64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 1'b1); tick();
    in_valid = 1'b0;
    wait_result(8, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL sat_next_timeout: got %b, expected 1", ok); end
    tests++; if (y !== 64'h0100_0100_0100_0100) begin fails++; $display("FAIL sat_next_y: got %h, expected 0100010001000100", y); end
    tests++; if (out_sat !== 4'h0) begin fails++; $display("FAIL sat_next_flags: got %h, expected 0", out_sat); end
    idle(3);
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    drive(64'h0200, 64'h0100, 1'b1); tick();
    in_valid = 1'b0;
    wait_result(8, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL bp_timeout: got %b, expected 1", ok); end
    // pending first beat of a 2-beat vector while the result sits unread
    drive(64'h0300, 64'h0100, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tests++;
      if ({in_ready, out_valid, y, out_len} !== {1'b0, 1'b1, 64'h0200, 10'd1}) begin
        fails++; $display("FAIL bp_hold cycle %0d: got rdy=%b vld=%b y=%h len=%0d, expected rdy=0 vld=1 y=0000000000000200 len=1",
                          c, in_ready, out_valid, y, out_len);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b, expected 1", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drop: got %b, expected 0", out_valid); end
    drive(64'h0100, 64'h0100, 1'b1); tick();
    in_valid = 1'b0; in_last = 1'b0;
    wait_result(8, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL bp_resume_timeout: got %b, expected 1", ok); end
    tests++; if (y !== 64'h0400) begin fails++; $display("FAIL bp_resume_y: got %h, expected 0000000000000400", y); end
    tests++; if (out_len !== 10'd2) begin fails++; $display("FAIL bp_resume_len: got %0d, expected 2", out_len); end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [15:0] xv;
    logic [15:0] ev;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        xv = 16'((c + 1) * 256);
        drive({48'h0, xv}, 64'h0100, 1'b1);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      tick();
      if (c < 3) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_early c=%0d: got %b, expected 0", c, out_valid); end
      end else begin
        ev = 16'((c - 2) * 256);
        tests++;
        if ({out_valid, y, out_len} !== {1'b1, 48'h0, ev, 10'd1}) begin
          fails++; $display("FAIL b2b_result c=%0d: got vld=%b y=%h len=%0d, expected vld=1 y=%h len=1",
                            c, out_valid, y, out_len, {48'h0, ev});
        end
      end
    end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b, expected 0", out_valid); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    out_ready = 1'b1;
    drive(64'h0100, 64'h0100, 1'b0); tick();
    drive(64'h0100, 64'h0100, 1'b0); tick();
    in_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if ({out_valid, y, out_sat, out_len} !== 79'h0) begin
      fails++; $display("FAIL rstmid_clear: got vld=%b y=%h sat=%h len=%0d, expected all 0", out_valid, y, out_sat, out_len);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_no_output: got %b, expected 0", seen); end
    drive(64'h0500, 64'h0100, 1'b1); tick();
    in_valid = 1'b0; in_last = 1'b0;
    wait_result(8, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rstmid_timeout: got %b, expected 1", ok); end
    tests++; if (y !== 64'h0500) begin fails++; $display("FAIL rstmid_y: got %h, expected 0000000000000500", y); end
    tests++; if (out_len !== 10'd1) begin fails++; $display("FAIL rstmid_len: got %0d, expected 1", out_len); end
    idle(3);
  endtask

  task automatic test_len_sat();
    bit ok;
    out_ready = 1'b1;
    for (int b = 0; b < 1025; b++) begin
      drive(64'h0, 64'h0, (b == 1024)); tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_result(8, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL lensat_timeout: got %b, expected 1", ok); end
    tests++; if (out_len !== 10'd1023) begin fails++; $display("FAIL lensat_len: got %0d, expected 1023", out_len); end
    tests++; if (y !== 64'h0) begin fails++; $display("FAIL lensat_y: got %h, expected 0", y); end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_len_sat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
